modexp_slot_scheduler: RTL and testbench

- Shares one modular-exponentiation engine (result = base^exp mod mod) between two requesters.
- Requesters are key-gen/decrypt clients of the RSA datapath.
- Every granted operation occupies a fixed-length time slot. The response latency is therefore independent of operand values and engine run time. This makes the block itself constant-time, so the two-copy finish-equivalence property holds across it.
- Sits between the RSA control logic and the exponentiation engine.

---
 rtl/modexp_slot_scheduler.sv | 135 +++++++++++++
 tb/tb_modexp_slot_scheduler.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/modexp_slot_scheduler.sv
// Two-requester arbiter for a shared modular-exponentiation engine.
// Every grant occupies a fixed SLOT_CYCLES window, so response timing never depends on operands or engine speed.
module modexp_slot_scheduler #(
  parameter int WIDTH       = 8,
  parameter int SLOT_CYCLES = 64
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [1:0]       req,
  input  logic [WIDTH-1:0] base_0,
  input  logic [WIDTH-1:0] exp_0,
  input  logic [WIDTH-1:0] mod_0,
  input  logic [WIDTH-1:0] base_1,
  input  logic [WIDTH-1:0] exp_1,
  input  logic [WIDTH-1:0] mod_1,
  output logic [1:0]       ack,
  output logic [1:0]       rsp_valid,
  output logic [WIDTH-1:0] rsp_data,
  output logic             rsp_err,
  output logic             eng_start,
  output logic [WIDTH-1:0] eng_base,
  output logic [WIDTH-1:0] eng_exp,
  output logic [WIDTH-1:0] eng_mod,
  input  logic             eng_done,
  input  logic [WIDTH-1:0] eng_result,
  output logic             busy,
  output logic             owner
);

  localparam int CW = $clog2(SLOT_CYCLES + 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    RUN   = 2'd2,
    RESP  = 2'd3
  } state_t;

  state_t           state;
  logic [CW-1:0]    timer;
  logic             rr;
  logic             captured;
  logic             illegal;
  logic [WIDTH-1:0] result;

  // Handshake: a requester holds req high until it sees ack[i] for one cycle;
  // the operands are latched on that same edge and may change afterwards.
  // The response is a single rsp_valid[i] pulse exactly SLOT_CYCLES after ack.
  logic             grant_id;
  logic             have_result;
  logic [WIDTH-1:0] final_result;

  assign grant_id     = (req == 2'b11) ? rr : req[1];
  // A done arriving on the closing RUN edge still counts as in-slot.
  assign have_result  = captured | eng_done;
  assign final_result = captured ? result : eng_result;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      timer     <= '0;
      rr        <= 1'b0;
      owner     <= 1'b0;
      captured  <= 1'b0;
      illegal   <= 1'b0;
      result    <= '0;
      ack       <= 2'b00;
      rsp_valid <= 2'b00;
      rsp_data  <= '0;
      rsp_err   <= 1'b0;
      eng_start <= 1'b0;
      eng_base  <= '0;
      eng_exp   <= '0;
      eng_mod   <= '0;
      busy      <= 1'b0;
    end else begin
      ack       <= 2'b00;
      rsp_valid <= 2'b00;
      rsp_data  <= '0;
      rsp_err   <= 1'b0;
      eng_start <= 1'b0;
      case (state)
        IDLE: begin
          if (req != 2'b00) begin
            if (req == 2'b11) rr <= ~rr;
            owner    <= grant_id;
            ack      <= grant_id ? 2'b10 : 2'b01;
            eng_base <= grant_id ? base_1 : base_0;
            eng_exp  <= grant_id ? exp_1 : exp_0;
            eng_mod  <= grant_id ? mod_1 : mod_0;
            busy     <= 1'b1;
            state    <= ISSUE;
          end
        end
        ISSUE: begin
          // A modulus of 0 or 1 is never sent to the engine; the slot still runs.
          illegal   <= (eng_mod < WIDTH'(2));
          eng_start <= (eng_mod >= WIDTH'(2));
          timer     <= CW'(1);
          state     <= RUN;
        end
        RUN: begin
          timer <= timer + CW'(1);
          if (eng_done && !captured) begin
            captured <= 1'b1;
            result   <= eng_result;
          end
          if (timer == CW'(SLOT_CYCLES - 1)) begin
            state            <= RESP;
            rsp_valid[owner] <= 1'b1;
            if (have_result && !illegal) begin
              rsp_data <= final_result;
              rsp_err  <= 1'b0;
            end else begin
              rsp_data <= '0;
              rsp_err  <= 1'b1;
            end
          end
        end
        RESP: begin
          captured <= 1'b0;
          illegal  <= 1'b0;
          timer    <= '0;
          busy     <= 1'b0;
          state    <= IDLE;
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_modexp_slot_scheduler.sv
// Scoreboard bench for modexp_slot_scheduler: directed requests, a behavioural engine,
// and a negedge monitor that checks grants, operands, responses and slot latency.
module tb_modexp_slot_scheduler;

  localparam int W    = 8;
  localparam int SLOT = 64;

  logic         clk = 1'b0;
  logic         rst;
  logic [1:0]   req;
  logic [W-1:0] base_0, exp_0, mod_0, base_1, exp_1, mod_1;
  logic [1:0]   ack, rsp_valid;
  logic [W-1:0] rsp_data, eng_base, eng_exp, eng_mod, eng_result;
  logic         rsp_err, eng_start, eng_done, busy, owner;

  modexp_slot_scheduler #(.WIDTH(W), .SLOT_CYCLES(SLOT)) dut (
    .clk(clk), .rst(rst), .req(req),
    .base_0(base_0), .exp_0(exp_0), .mod_0(mod_0),
    .base_1(base_1), .exp_1(exp_1), .mod_1(mod_1),
    .ack(ack), .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_err(rsp_err),
    .eng_start(eng_start), .eng_base(eng_base), .eng_exp(eng_exp), .eng_mod(eng_mod),
    .eng_done(eng_done), .eng_result(eng_result), .busy(busy), .owner(owner)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int total = 0;
  int bad   = 0;

  // {starts, rsp_valid[1:0], rsp_err, rsp_data[7:0]}
  logic [11:0] exp_q[$];
  // {check_gap, ack[1:0], base, exp, mod}
  logic [26:0] ack_q[$];
  int last_ack    = 0;
  int slot_starts = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] want);
    total++;
    if (act !== want) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (cycle %0d)", name, act, want, cyc);
    end
  endtask

  // Behavioural engine
  int       eng_lat   = 10;
  bit       eng_never = 1'b0;
  bit       eng_twice = 1'b0;
  bit       stray     = 1'b0;
  int       eng_cnt   = 0;
  int       extra_cnt = 0;
  logic [W-1:0] pend_res;

  function automatic logic [W-1:0] modexp(input logic [W-1:0] b, input logic [W-1:0] e,
                                          input logic [W-1:0] m);
    int r = 1 % int'(m);
    for (int i = 0; i < int'(e); i++) r = (r * int'(b)) % int'(m);
    return W'(r);
  endfunction

  initial begin
    eng_done   = 1'b0;
    eng_result = '0;
    forever begin
      @(negedge clk);
      eng_done = 1'b0;
      if (rst) begin
        eng_cnt   = 0;
        extra_cnt = 0;
      end
      if (stray) begin
        eng_done   = 1'b1;
        eng_result = 8'hEE;
        stray      = 1'b0;
      end else if (eng_cnt > 0) begin
        eng_cnt--;
        if (eng_cnt == 0) begin
          eng_done   = 1'b1;
          eng_result = pend_res;
          if (eng_twice) extra_cnt = 3;
        end
      end else if (extra_cnt > 0) begin
        extra_cnt--;
        if (extra_cnt == 0) begin
          eng_done   = 1'b1;
          eng_result = pend_res ^ 8'h5A;
        end
      end
      if (eng_start && !eng_never && !rst) begin
        eng_cnt  = eng_lat;
        pend_res = modexp(eng_base, eng_exp, eng_mod);
      end
    end
  end

  // Monitor
  initial begin
    logic [26:0] a;
    logic [11:0] e;
    forever begin
      @(negedge clk);
      if (!rst) begin
        if (eng_start) slot_starts++;
        if (ack != 2'b00) begin
          if (ack_q.size() == 0) begin
            check("ack_unexpected", 64'(ack), 64'd0);
          end else begin
            a = ack_q.pop_front();
            check("ack", 64'(ack), 64'(a[25:24]));
            check("eng_ops", 64'({eng_base, eng_exp, eng_mod}), 64'(a[23:0]));
            check("owner", 64'(owner), 64'(a[25]));
            if (a[26]) check("ack_gap", 64'(cyc - last_ack), 64'd66);
          end
          last_ack    = cyc;
          slot_starts = 0;
        end
        if (rsp_valid != 2'b00) begin
          if (exp_q.size() == 0) begin
            check("rsp_unexpected", 64'(rsp_valid), 64'd0);
          end else begin
            e = exp_q.pop_front();
            check("rsp_valid", 64'(rsp_valid), 64'(e[10:9]));
            check("rsp_err", 64'(rsp_err), 64'(e[8]));
            check("rsp_data", 64'(rsp_data), 64'(e[7:0]));
            check("rsp_latency", 64'(cyc - last_ack), 64'(SLOT));
            check("eng_starts", 64'(slot_starts), 64'(e[11]));
          end
        end else begin
          check("rsp_idle_zero", 64'({rsp_err, rsp_data}), 64'd0);
        end
      end
    end
  end

  task automatic wait_ack();
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (ack == 2'b00 && n < 300);
    if (ack == 2'b00) check("ack_timeout", 64'(ack), 64'd1);
  endtask

  task automatic wait_idle();
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while ((busy || exp_q.size() != 0) && n < 400);
    if (busy || exp_q.size() != 0) check("idle_timeout", 64'(exp_q.size()), 64'd0);
  endtask

  task automatic set_ops(input bit id, input logic [W-1:0] b, input logic [W-1:0] e,
                         input logic [W-1:0] m);
    if (id) begin
      base_1 = b; exp_1 = e; mod_1 = m;
    end else begin
      base_0 = b; exp_0 = e; mod_0 = m;
    end
  endtask

  task automatic request(input bit id, input logic [W-1:0] b, input logic [W-1:0] e,
                         input logic [W-1:0] m, input bit starts, input bit err,
                         input logic [W-1:0] data);
    logic [1:0] onehot;
    onehot = id ? 2'b10 : 2'b01;
    ack_q.push_back({1'b0, onehot, b, e, m});
    exp_q.push_back({starts, onehot, err, data});
    set_ops(id, b, e, m);
    req = onehot;
    wait_ack();
    req = 2'b00;
    set_ops(id, 8'hFF, 8'hFF, 8'hFF);
  endtask

  initial begin
    rst = 1'b1;
    req = 2'b00;
    set_ops(1'b0, '0, '0, '0);
    set_ops(1'b1, '0, '0, '0);
    repeat (3) @(negedge clk);
    check("reset_outputs", 64'({ack, rsp_valid, rsp_data, rsp_err, eng_start, eng_base,
                                eng_exp, eng_mod, busy, owner}), 64'd0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // Single request: 5^3 mod 33 = 26
    eng_lat = 10;
    request(1'b0, 8'd5, 8'd3, 8'd33, 1'b1, 1'b0, 8'd26);
    wait_idle();

    // Constant time across engine latencies
    eng_lat = 1;
    request(1'b1, 8'd7, 8'd2, 8'd10, 1'b1, 1'b0, 8'd9);
    wait_idle();
    eng_lat = 30;
    request(1'b0, 8'd4, 8'd0, 8'd9, 1'b1, 1'b0, 8'd1);
    wait_idle();
    eng_lat = 62;
    request(1'b1, 8'd3, 8'd4, 8'd7, 1'b1, 1'b0, 8'd4);
    wait_idle();

    // Contention: req=11 held, grants alternate 0,1,0,1 every 66 cycles
    eng_lat = 20;
    set_ops(1'b0, 8'd2, 8'd5, 8'd31);
    set_ops(1'b1, 8'd3, 8'd3, 8'd20);
    for (int k = 0; k < 4; k++) begin
      if (k % 2 == 0) begin
        ack_q.push_back({(k != 0), 2'b01, 8'd2, 8'd5, 8'd31});
        exp_q.push_back({1'b1, 2'b01, 1'b0, 8'd1});
      end else begin
        ack_q.push_back({1'b1, 2'b10, 8'd3, 8'd3, 8'd20});
        exp_q.push_back({1'b1, 2'b10, 1'b0, 8'd7});
      end
    end
    req = 2'b11;
    for (int k = 0; k < 4; k++) wait_ack();
    req = 2'b00;
    wait_idle();

    // Illegal modulus, then engine timeout
    request(1'b1, 8'd9, 8'd9, 8'd1, 1'b0, 1'b1, 8'd0);
    wait_idle();
    eng_never = 1'b1;
    request(1'b0, 8'd5, 8'd3, 8'd33, 1'b1, 1'b1, 8'd0);
    wait_idle();

    // Reset at timer=20, stale done afterwards, then a fresh slot
    ack_q.push_back({1'b0, 2'b01, 8'd5, 8'd3, 8'd33});
    set_ops(1'b0, 8'd5, 8'd3, 8'd33);
    req = 2'b01;
    wait_ack();
    req = 2'b00;
    repeat (20) @(negedge clk);
    rst = 1'b1;
    #1;
    check("reset_midslot", 64'({ack, rsp_valid, rsp_data, rsp_err, eng_start, eng_base,
                                eng_exp, eng_mod, busy, owner}), 64'd0);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    eng_never = 1'b0;
    repeat (5) @(negedge clk);
    stray = 1'b1;
    repeat (4) @(negedge clk);
    check("stale_done_busy", 64'(busy), 64'd0);
    eng_lat = 10;
    request(1'b0, 8'd5, 8'd3, 8'd33, 1'b1, 1'b0, 8'd26);
    wait_idle();

    // Stray done in IDLE, then two dones in RUN: first result wins (6^2 mod 11 = 3)
    stray = 1'b1;
    repeat (3) @(negedge clk);
    check("stray_idle_busy", 64'(busy), 64'd0);
    eng_twice = 1'b1;
    request(1'b1, 8'd6, 8'd2, 8'd11, 1'b1, 1'b0, 8'd3);
    wait_idle();
    eng_twice = 1'b0;

    repeat (5) @(negedge clk);
    check("ack_q_drained", 64'(ack_q.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
